// File: rtl/led_matrix_pkg.sv
// Shared types and helpers for the LED matrix scanner: scan phase encoding,
// PWM slot count and the per-pixel intensity-versus-slot compare.
package led_matrix_pkg;

    typedef enum logic {
        BLANKING = 1'b0,
        DRIVE    = 1'b1
    } scan_state_t;

    function automatic int slots_for(input int pwm_bits);
        return (1 << pwm_bits) - 1;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Slot-based PWM: a pixel is lit in slot s when its intensity exceeds s.
    function automatic logic pixel_on(input int intensity, input int slot);
        return intensity > slot;
    endfunction

endpackage

// File: rtl/led_matrix_scanner_row_encoder.sv
// Combinational row encoder: turns the active frame, a scan row and a PWM slot
// into the 3*COLS column-drive word (red low, then green, then blue).
module led_row_encoder
    import led_matrix_pkg::*;
#(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int PWM_BITS = 2,
    parameter int R_W      = 3,
    parameter int S_W      = 2
) (
    input  logic [COLS-1:0][ROWS-1:0][PWM_BITS-1:0] red,
    input  logic [COLS-1:0][ROWS-1:0][PWM_BITS-1:0] green,
    input  logic [COLS-1:0][ROWS-1:0][PWM_BITS-1:0] blue,
    input  logic [R_W-1:0]                          row,
    input  logic [S_W-1:0]                          slot,
    output logic [3*COLS-1:0]                       row_word
);

    logic [R_W-1:0] src_row;

    // The board is wired mirrored in both axes relative to the frame indexing.
    always_comb begin
        row_word = '0;
        src_row  = R_W'(ROWS - 1) - row;
        for (int k = 0; k < COLS; k++) begin
            row_word[k]          = pixel_on(int'(red[COLS-1-k][src_row]), int'(slot));
            row_word[COLS+k]     = pixel_on(int'(green[COLS-1-k][src_row]), int'(slot));
            row_word[2*COLS+k]   = pixel_on(int'(blue[COLS-1-k][src_row]), int'(slot));
        end
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// Time-multiplexed RGB LED matrix driver: double-buffered frame load, row scan
// with slot PWM and a blanking interval at the start of every slot.
//
//   state    | meaning
//   BLANKING | d < BLANK, board and row_sel forced to zero
//   DRIVE    | current row enabled, columns driven from the active frame
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int PWM_BITS = 2,
    parameter int DWELL    = 1024,
    parameter int BLANK    = 2
) (
    input  logic                                    clock,
    input  logic                                    reset_n,
    input  logic [COLS-1:0][ROWS-1:0][PWM_BITS-1:0] red,
    input  logic [COLS-1:0][ROWS-1:0][PWM_BITS-1:0] green,
    input  logic [COLS-1:0][ROWS-1:0][PWM_BITS-1:0] blue,
    input  logic                                    load_valid,
    output logic                                    load_ready,
    output logic [3*COLS-1:0]                       board,
    output logic [ROWS-1:0]                         row_sel,
    output logic                                    frame_done
);

    localparam int SLOTS = slots_for(PWM_BITS);
    localparam int R_W   = cnt_width(ROWS);
    localparam int S_W   = cnt_width(SLOTS);
    localparam int D_W   = cnt_width(DWELL);
    localparam scan_state_t STATE_RST = (BLANK > 0) ? BLANKING : DRIVE;

    typedef logic [COLS-1:0][ROWS-1:0][PWM_BITS-1:0] plane_t;

    plane_t pend_r_q, pend_g_q, pend_b_q, pend_r_d, pend_g_d, pend_b_d;
    plane_t act_r_q, act_g_q, act_b_q, act_r_d, act_g_d, act_b_d;
    logic   pending_full_q, pending_full_d;

    logic [R_W-1:0] r_q, r_d;
    logic [S_W-1:0] s_q, s_d;
    logic [D_W-1:0] d_q, d_d;

    scan_state_t state_q, state_d;

    logic [3*COLS-1:0] board_q, board_d;
    logic [ROWS-1:0]   row_sel_q, row_sel_d;
    logic              frame_done_q, frame_done_d;

    logic              accept, last_d, last_s, last_r, frame_last;
    logic [3*COLS-1:0] row_word;
    logic [ROWS-1:0]   row_one;

    led_row_encoder #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .PWM_BITS (PWM_BITS),
        .R_W      (R_W),
        .S_W      (S_W)
    ) u_row_encoder (
        .red      (act_r_q),
        .green    (act_g_q),
        .blue     (act_b_q),
        .row      (r_q),
        .slot     (s_q),
        .row_word (row_word)
    );

    assign load_ready = !pending_full_q;
    assign board      = board_q;
    assign row_sel    = row_sel_q;
    assign frame_done = frame_done_q;

    always_comb begin
        last_d     = (d_q == D_W'(DWELL - 1));
        last_s     = (s_q == S_W'(SLOTS - 1));
        last_r     = (r_q == R_W'(ROWS - 1));
        frame_last = last_d && last_s && last_r;

        d_d = last_d ? '0 : d_q + 1'b1;
        s_d = s_q;
        r_d = r_q;
        if (last_d) begin
            s_d = last_s ? '0 : s_q + 1'b1;
            if (last_s) begin
                r_d = last_r ? '0 : r_q + 1'b1;
            end
        end

        // Registered so the pulse lines up with the cycle whose counters are last.
        frame_done_d = (d_d == D_W'(DWELL - 1)) && (s_d == S_W'(SLOTS - 1)) &&
                       (r_d == R_W'(ROWS - 1));
    end

    // Accept and swap never coincide: accept needs an empty pending buffer.
    always_comb begin
        accept         = load_valid && !pending_full_q;
        pend_r_d       = pend_r_q;
        pend_g_d       = pend_g_q;
        pend_b_d       = pend_b_q;
        act_r_d        = act_r_q;
        act_g_d        = act_g_q;
        act_b_d        = act_b_q;
        pending_full_d = pending_full_q;
        if (accept) begin
            pend_r_d       = red;
            pend_g_d       = green;
            pend_b_d       = blue;
            pending_full_d = 1'b1;
        end
        if (frame_last && pending_full_q) begin
            act_r_d        = pend_r_q;
            act_g_d        = pend_g_q;
            act_b_d        = pend_b_q;
            pending_full_d = 1'b0;
        end
    end

    always_comb begin
        state_d   = (int'(d_d) < BLANK) ? BLANKING : DRIVE;
        row_one   = '0;
        row_one[r_q] = 1'b1;
        board_d   = '0;
        row_sel_d = '0;
        if (state_q == DRIVE) begin
            board_d   = row_word;
            row_sel_d = row_one;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STATE_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_r_q       <= '0;
            pend_g_q       <= '0;
            pend_b_q       <= '0;
            act_r_q        <= '0;
            act_g_q        <= '0;
            act_b_q        <= '0;
            pending_full_q <= 1'b0;
            r_q            <= '0;
            s_q            <= '0;
            d_q            <= '0;
            board_q        <= '0;
            row_sel_q      <= '0;
            frame_done_q   <= 1'b0;
        end else begin
            pend_r_q       <= pend_r_d;
            pend_g_q       <= pend_g_d;
            pend_b_q       <= pend_b_d;
            act_r_q        <= act_r_d;
            act_g_q        <= act_g_d;
            act_b_q        <= act_b_d;
            pending_full_q <= pending_full_d;
            r_q            <= r_d;
            s_q            <= s_d;
            d_q            <= d_d;
            board_q        <= board_d;
            row_sel_q      <= row_sel_d;
            frame_done_q   <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner with ROWS=COLS=8, PWM_BITS=2, DWELL=4,
// BLANK=1 (96-cycle frame); outputs are sampled on the falling edge.
module tb_led_matrix_scanner;

    logic                       clock;
    logic                       reset_n;
    logic [7:0][7:0][1:0]       red, green, blue;
    logic                       load_valid;
    logic                       load_ready;
    logic [23:0]                board;
    logic [7:0]                 row_sel;
    logic                       frame_done;

    int passed = 0;
    int total  = 0;
    int cyc;

    led_matrix_scanner #(
        .ROWS     (8),
        .COLS     (8),
        .PWM_BITS (2),
        .DWELL    (4),
        .BLANK    (1)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .board      (board),
        .row_sel    (row_sel),
        .frame_done (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Posedges since reset release; at a falling edge, cyc equals the counter index.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic goto(input int target);
        int n;
        n = target - cyc;
        if (n < 0) begin
            total++;
            $display("FAIL goto: cyc %0d already past target %0d", cyc, target);
        end else begin
            repeat (n) @(negedge clock);
        end
    endtask

    task automatic clear_inputs();
        red = '0; green = '0; blue = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; load_valid = 1'b0; clear_inputs();
        repeat (3) @(negedge clock);
        total++; if (board !== 24'h0) $display("FAIL rst_board: got %h want %h", board, 24'h0); else passed++;
        total++; if (row_sel !== 8'h0) $display("FAIL rst_row_sel: got %h want %h", row_sel, 8'h0); else passed++;
        total++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done: got %b want 0", frame_done); else passed++;
        total++; if (load_ready !== 1'b1) $display("FAIL rst_load_ready: got %b want 1", load_ready); else passed++;
        reset_n = 1'b1;
    endtask

    task automatic test_single_red();
        int pos, r, s, d;
        logic [23:0] exp_b;
        logic [7:0]  exp_rs;
        logic        exp_fd;
        clear_inputs();
        red[7][7] = 2'd3;
        load_valid = 1'b1;
        goto(1);
        load_valid = 1'b0;
        total++; if (load_ready !== 1'b0) $display("FAIL red_accept_ready: got %b want 0", load_ready); else passed++;
        goto(2);
        total++; if (board !== 24'h0) $display("FAIL red_pre_swap: got %h want %h", board, 24'h0); else passed++;
        total++; if (row_sel !== 8'h01) $display("FAIL red_pre_swap_rs: got %h want %h", row_sel, 8'h01); else passed++;
        goto(95);
        total++; if (frame_done !== 1'b1) $display("FAIL red_fd0: got %b want 1", frame_done); else passed++;
        goto(96);
        total++; if (load_ready !== 1'b1) $display("FAIL red_ready_after_swap: got %b want 1", load_ready); else passed++;
        for (int c = 97; c <= 192; c++) begin
            goto(c);
            pos = (c - 1) % 96; r = pos / 12; s = (pos % 12) / 4; d = pos % 4;
            exp_rs = (d >= 1) ? (8'h01 << r) : 8'h00;
            exp_b  = (r == 0 && d >= 1) ? 24'h000001 : 24'h000000;
            exp_fd = (c % 96 == 95);
            total++; if (board !== exp_b) $display("FAIL red_scan_board c=%0d r=%0d s=%0d d=%0d: got %h want %h", c, r, s, d, board, exp_b); else passed++;
            total++; if (row_sel !== exp_rs) $display("FAIL red_scan_rs c=%0d: got %h want %h", c, row_sel, exp_rs); else passed++;
            total++; if (!$onehot0(row_sel)) $display("FAIL red_scan_onehot c=%0d: got %h want at most one bit", c, row_sel); else passed++;
            total++; if (frame_done !== exp_fd) $display("FAIL red_scan_fd c=%0d: got %b want %b", c, frame_done, exp_fd); else passed++;
        end
    endtask

    task automatic test_green_corner();
        int pos, r, s, d;
        logic [23:0] exp_b;
        logic [7:0]  exp_rs;
        clear_inputs();
        green[0][0] = 2'd1;
        load_valid = 1'b1;
        goto(193);
        load_valid = 1'b0;
        clear_inputs();
        total++; if (load_ready !== 1'b0) $display("FAIL green_accept_ready: got %b want 0", load_ready); else passed++;
        for (int c = 289; c <= 384; c++) begin
            goto(c);
            pos = (c - 1) % 96; r = pos / 12; s = (pos % 12) / 4; d = pos % 4;
            exp_rs = (d >= 1) ? (8'h01 << r) : 8'h00;
            exp_b  = (r == 7 && s == 0 && d >= 1) ? 24'h008000 : 24'h000000;
            total++; if (board !== exp_b) $display("FAIL green_scan_board c=%0d r=%0d s=%0d d=%0d: got %h want %h", c, r, s, d, board, exp_b); else passed++;
            total++; if (row_sel !== exp_rs) $display("FAIL green_scan_rs c=%0d: got %h want %h", c, row_sel, exp_rs); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int f1;
        clear_inputs();
        red[7][7] = 2'd3;
        load_valid = 1'b1;
        @(negedge clock);
        total++; if (load_ready !== 1'b0) $display("FAIL b2b_a_accept: got %b want 0", load_ready); else passed++;
        clear_inputs();
        green[7][7] = 2'd3;
        f1 = (cyc / 96 + 1) * 96;
        goto(f1 - 1);
        total++; if (load_ready !== 1'b0) $display("FAIL b2b_b_held: got %b want 0", load_ready); else passed++;
        total++; if (frame_done !== 1'b1) $display("FAIL b2b_fd_a: got %b want 1", frame_done); else passed++;
        goto(f1);
        total++; if (load_ready !== 1'b1) $display("FAIL b2b_ready_after_a_swap: got %b want 1", load_ready); else passed++;
        goto(f1 + 1);
        total++; if (load_ready !== 1'b0) $display("FAIL b2b_b_accept: got %b want 0", load_ready); else passed++;
        clear_inputs();
        blue[7][7] = 2'd3;
        goto(f1 + 2);
        total++; if (board !== 24'h000001) $display("FAIL b2b_active_a: got %h want %h", board, 24'h000001); else passed++;
        total++; if (row_sel !== 8'h01) $display("FAIL b2b_active_a_rs: got %h want %h", row_sel, 8'h01); else passed++;
        goto(f1 + 95);
        total++; if (load_ready !== 1'b0) $display("FAIL b2b_c_waits: got %b want 0", load_ready); else passed++;
        goto(f1 + 96);
        total++; if (load_ready !== 1'b1) $display("FAIL b2b_ready_after_b_swap: got %b want 1", load_ready); else passed++;
        goto(f1 + 97);
        total++; if (load_ready !== 1'b0) $display("FAIL b2b_c_accept: got %b want 0", load_ready); else passed++;
        load_valid = 1'b0;
        clear_inputs();
        goto(f1 + 98);
        total++; if (board !== 24'h000100) $display("FAIL b2b_active_b: got %h want %h", board, 24'h000100); else passed++;
        goto(f1 + 191);
        total++; if (load_ready !== 1'b0) $display("FAIL b2b_c_pending: got %b want 0", load_ready); else passed++;
        goto(f1 + 192);
        total++; if (load_ready !== 1'b1) $display("FAIL b2b_ready_after_c_swap: got %b want 1", load_ready); else passed++;
        goto(f1 + 194);
        total++; if (board !== 24'h010000) $display("FAIL b2b_active_c: got %h want %h", board, 24'h010000); else passed++;
    endtask

    task automatic test_load_at_frame_done();
        int f;
        f = (cyc / 96 + 1) * 96;
        goto(f - 1);
        total++; if (frame_done !== 1'b1) $display("FAIL fdload_fd: got %b want 1", frame_done); else passed++;
        total++; if (load_ready !== 1'b1) $display("FAIL fdload_ready: got %b want 1", load_ready); else passed++;
        clear_inputs();
        red[7][7] = 2'd1;
        load_valid = 1'b1;
        goto(f);
        load_valid = 1'b0;
        clear_inputs();
        total++; if (load_ready !== 1'b0) $display("FAIL fdload_accept: got %b want 0", load_ready); else passed++;
        goto(f + 2);
        total++; if (board !== 24'h010000) $display("FAIL fdload_active_unchanged: got %h want %h", board, 24'h010000); else passed++;
        goto(f + 95);
        total++; if (frame_done !== 1'b1) $display("FAIL fdload_fd2: got %b want 1", frame_done); else passed++;
        goto(f + 96);
        total++; if (load_ready !== 1'b1) $display("FAIL fdload_swapped_ready: got %b want 1", load_ready); else passed++;
        goto(f + 98);
        total++; if (board !== 24'h000001) $display("FAIL fdload_new_slot0: got %h want %h", board, 24'h000001); else passed++;
        goto(f + 102);
        total++; if (board !== 24'h000000) $display("FAIL fdload_new_slot1: got %h want %h", board, 24'h000000); else passed++;
        total++; if (row_sel !== 8'h01) $display("FAIL fdload_new_slot1_rs: got %h want %h", row_sel, 8'h01); else passed++;
    endtask

    task automatic test_reset_midframe();
        int f;
        logic exp_fd;
        clear_inputs();
        red[7][7] = 2'd3;
        load_valid = 1'b1;
        @(negedge clock);
        load_valid = 1'b0;
        f = (cyc / 96 + 1) * 96;
        goto(f);
        clear_inputs();
        blue[0][0] = 2'd3;
        load_valid = 1'b1;
        @(negedge clock);
        load_valid = 1'b0;
        clear_inputs();
        total++; if (load_ready !== 1'b0) $display("FAIL mid_pending_full: got %b want 0", load_ready); else passed++;
        goto(f + 2);
        total++; if (board !== 24'h000001) $display("FAIL mid_pre_board: got %h want %h", board, 24'h000001); else passed++;
        reset_n = 1'b0;
        #1;
        total++; if (board !== 24'h0) $display("FAIL mid_rst_board: got %h want %h", board, 24'h0); else passed++;
        total++; if (row_sel !== 8'h0) $display("FAIL mid_rst_rs: got %h want %h", row_sel, 8'h0); else passed++;
        total++; if (frame_done !== 1'b0) $display("FAIL mid_rst_fd: got %b want 0", frame_done); else passed++;
        total++; if (load_ready !== 1'b1) $display("FAIL mid_rst_ready: got %b want 1", load_ready); else passed++;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int c = 1; c <= 96; c++) begin
            goto(c);
            exp_fd = (c == 95);
            total++; if (frame_done !== exp_fd) $display("FAIL mid_fd_timing c=%0d: got %b want %b", c, frame_done, exp_fd); else passed++;
            if (c == 2) begin
                total++; if (board !== 24'h0) $display("FAIL mid_active_cleared: got %h want %h", board, 24'h0); else passed++;
            end
        end
        goto(98);
        total++; if (board !== 24'h0) $display("FAIL mid_pending_discarded_r0: got %h want %h", board, 24'h0); else passed++;
        goto(182);
        total++; if (board !== 24'h0) $display("FAIL mid_pending_discarded_r7: got %h want %h", board, 24'h0); else passed++;
        total++; if (row_sel !== 8'h80) $display("FAIL mid_r7_rs: got %h want %h", row_sel, 8'h80); else passed++;
    endtask

    initial begin
        reset_n = 1'b0;
        load_valid = 1'b0;
        clear_inputs();
        @(negedge clock);
        test_reset();
        test_single_red();
        test_green_corner();
        test_back_to_back();
        test_load_at_frame_done();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
